// File: rtl/iob_addsub_mp.sv
// Limb-serial multi-precision signed adder/subtractor.
// Operands stream in least-significant limb first. The carry is chained across limbs, and flags are reported on the last limb.
module iob_addsub_mp #(
  parameter int DATA_W    = 32,
  parameter int MAX_LIMBS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic              op,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] res,
  output logic              out_last,
  output logic              carry,
  output logic              overflow,
  output logic              zero,
  output logic              len_err
);

  localparam int CNT_W = $clog2(MAX_LIMBS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_LIMBS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             carry_reg;
  logic             op_reg;
  logic             zero_acc;

  logic              accept;
  logic              first;
  logic              cur_op;
  logic              cin;
  logic              is_last;
  logic              forced;
  logic [DATA_W:0]   sum_mid;
  logic [DATA_W:0]   sum_top;
  logic [DATA_W-1:0] res_nxt;
  logic              zero_nxt;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    first    = (state == IDLE);
    cur_op   = first ? op : op_reg;
    cin      = first ? op : carry_reg;
    // cnt is 0 in IDLE, so this also covers MAX_LIMBS==1 on the first limb
    forced   = (cnt == LAST_CNT);
    is_last  = in_last || forced;
    sum_mid  = {1'b0, op_a} + {1'b0, op_b ^ {DATA_W{cur_op}}} + {{DATA_W{1'b0}}, cin};
    sum_top  = {op_a[DATA_W-1], op_a}
             + ({(DATA_W+1){cur_op}} ^ {op_b[DATA_W-1], op_b})
             + {{DATA_W{1'b0}}, cin};
    res_nxt  = is_last ? sum_top[DATA_W-1:0] : sum_mid[DATA_W-1:0];
    zero_nxt = (first || zero_acc) && (res_nxt == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      carry_reg <= 1'b0;
      op_reg    <= 1'b0;
      zero_acc  <= 1'b1;
      out_valid <= 1'b0;
      res       <= '0;
      out_last  <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      len_err   <= 1'b0;
    end else if (accept) begin
      if (first) op_reg <= op;
      zero_acc <= zero_nxt;
      if (is_last) begin
        state     <= IDLE;
        cnt       <= '0;
        carry_reg <= 1'b0;
      end else begin
        state     <= RUN;
        cnt       <= cnt + CNT_W'(1);
        carry_reg <= sum_mid[DATA_W];
      end
      out_valid <= 1'b1;
      res       <= res_nxt;
      out_last  <= is_last;
      carry     <= is_last && sum_top[DATA_W];
      overflow  <= is_last && (sum_top[DATA_W] ^ sum_top[DATA_W-1]);
      zero      <= is_last && zero_nxt;
      len_err   <= is_last && forced && !in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      len_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_iob_addsub_mp.sv
// Directed bench for iob_addsub_mp (DATA_W=32, MAX_LIMBS=4).
// Expected values are hand-computed.
module tb_iob_addsub_mp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_last = 1'b0;
  logic        op = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] res;
  logic        out_last;
  logic        carry;
  logic        overflow;
  logic        zero;
  logic        len_err;

  int n_cmp = 0;
  int n_bad = 0;

  iob_addsub_mp #(.DATA_W(32), .MAX_LIMBS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .op(op),
    .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .res(res), .out_last(out_last),
    .carry(carry), .overflow(overflow), .zero(zero), .len_err(len_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] e_res, input logic e_last,
                         input logic e_c, input logic e_v, input logic e_z, input logic e_l);
    check({tag, ".valid"}, out_valid, 1'b1);
    check({tag, ".res"}, res, e_res);
    check({tag, ".last"}, out_last, e_last);
    check({tag, ".carry"}, carry, e_c);
    check({tag, ".ovf"}, overflow, e_v);
    check({tag, ".zero"}, zero, e_z);
    check({tag, ".len_err"}, len_err, e_l);
  endtask

  // Drive one limb at negedge, let it be accepted at posedge, sample #1 later.
  task automatic put(input logic [31:0] a, input logic [31:0] b, input logic o, input logic l);
    @(negedge clk);
    in_valid = 1'b1; op_a = a; op_b = b; op = o; in_last = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    check("rst.valid", out_valid, 1'b0);
    check("rst.res", res, 32'h0);
    check("rst.flags", {out_last, carry, overflow, zero, len_err}, 5'b0);
    check("rst.in_ready", in_ready, 1'b1);
    @(negedge clk); rst_n = 1'b1;

    // Single-limb signed overflow
    put(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1);
    chk_out("t1", 32'h80000000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // Two-limb add with inter-limb carry
    put(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
    chk_out("add.l0", 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    put(32'h00000001, 32'h00000000, 1'b0, 1'b1);
    chk_out("add.l1", 32'h00000002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Two-limb subtract 0 - 1 = -1
    put(32'h0, 32'h1, 1'b1, 1'b0);
    chk_out("sub.l0", 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    put(32'h0, 32'h0, 1'b0, 1'b1);
    chk_out("sub.l1", 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // a - b with a == b gives zero
    put(32'h7, 32'h7, 1'b1, 1'b0);
    chk_out("eq.l0", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    put(32'h5, 32'h5, 1'b0, 1'b1);
    chk_out("eq.l1", 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Back-pressure on a three-limb add
    put(32'h1, 32'h2, 1'b0, 1'b0);
    chk_out("bp.l0", 32'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    put(32'h10, 32'h20, 1'b0, 1'b0);
    chk_out("bp.l1", 32'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; op_a = 32'h100; op_b = 32'h200; op = 1'b0; in_last = 1'b1;
    #1;
    check("bp.in_ready_low", in_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("bp.hold.res", res, 32'h30);
      check("bp.hold.last", out_last, 1'b0);
      check("bp.hold.valid", out_valid, 1'b1);
      check("bp.hold.in_ready", in_ready, 1'b0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk_out("bp.l2", 32'h300, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("bp.drain.valid", out_valid, 1'b0);
    check("bp.drain.last", out_last, 1'b0);

    // Forced termination at MAX_LIMBS; the 5th limb starts a new subtract
    put(32'h1, 32'h0, 1'b0, 1'b0);
    chk_out("len.l0", 32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    put(32'h2, 32'h0, 1'b1, 1'b0);
    chk_out("len.l1", 32'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    put(32'h3, 32'h0, 1'b0, 1'b0);
    chk_out("len.l2", 32'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    put(32'h4, 32'h0, 1'b0, 1'b0);
    chk_out("len.l3", 32'h4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    put(32'h5, 32'h3, 1'b1, 1'b0);
    chk_out("len.new0", 32'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    put(32'h0, 32'h0, 1'b0, 1'b1);
    chk_out("len.new1", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset after limb 2 of 3
    put(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0);
    put(32'h0, 32'h0, 1'b0, 1'b0);
    chk_out("ar.l1", 32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("ar.valid", out_valid, 1'b0);
    check("ar.res", res, 32'h0);
    check("ar.flags", {out_last, carry, overflow, zero, len_err}, 5'b0);
    @(negedge clk); rst_n = 1'b1;
    put(32'h3, 32'h5, 1'b1, 1'b1);
    chk_out("ar.new", 32'hFFFFFFFE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
